// File: rtl/soc_system_pll_reconfig.sv
// Reconfiguration controller for soc_system_pll_0: the host programs shadow counters,
// START pushes the modified ones over reconfig_to_pll, then waits for the PLL to re-lock.
module soc_system_pll_reconfig #(
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [63:0] reconfig_to_pll,
    input  logic [63:0] reconfig_from_pll,
    output logic        irq
);
    typedef enum logic [2:0] {IDLE, PUSH, START, SETTLE, WAIT_BUSY, WAIT_LOCK} state_t;

    localparam logic [15:0] LOCK_LIMIT = 16'(LOCK_TIMEOUT);
    localparam logic [15:0] N_RST      = 16'h0202;
    localparam logic [15:0] M_RST      = 16'h3737;
    localparam logic [17:0] C0_RST     = 18'h20302;
    localparam logic [31:0] K_RST      = 32'h0CCCCCCD;
    localparam logic [5:0]  ADDR_N     = 6'h03;
    localparam logic [5:0]  ADDR_M     = 6'h04;
    localparam logic [5:0]  ADDR_C0    = 6'h05;
    localparam logic [5:0]  ADDR_K     = 6'h07;

    state_t      state, state_n;
    logic [15:0] n_cnt, n_cnt_n, m_cnt, m_cnt_n;
    logic [17:0] c0_cnt, c0_cnt_n;
    logic [31:0] k_frac, k_frac_n;
    logic [3:0]  dirty, dirty_n, pend, pend_n, push_cur, push_next;
    logic        done, done_n, err, err_n, rejected, rejected_n;
    logic        settle_cnt, settle_cnt_n;
    logic [15:0] lock_cnt, lock_cnt_n;
    logic [63:0] to_pll_n;
    logic [31:0] readdata_n;
    logic        irq_n, idle, pll_busy, pll_locked;
    logic        unused_from_pll;

    assign idle            = (state == IDLE);
    assign pll_busy        = reconfig_from_pll[0];
    assign pll_locked      = reconfig_from_pll[1];
    assign unused_from_pll = ^reconfig_from_pll[63:2];

    always_ff @(posedge refclk) begin
        if (rst) begin
            state           <= IDLE;
            n_cnt           <= N_RST;
            m_cnt           <= M_RST;
            c0_cnt          <= C0_RST;
            k_frac          <= K_RST;
            dirty           <= '0;
            pend            <= '0;
            done            <= 1'b0;
            err             <= 1'b0;
            rejected        <= 1'b0;
            settle_cnt      <= 1'b0;
            lock_cnt        <= '0;
            reconfig_to_pll <= '0;
            avs_readdata    <= '0;
            irq             <= 1'b0;
        end else begin
            state           <= state_n;
            n_cnt           <= n_cnt_n;
            m_cnt           <= m_cnt_n;
            c0_cnt          <= c0_cnt_n;
            k_frac          <= k_frac_n;
            dirty           <= dirty_n;
            pend            <= pend_n;
            done            <= done_n;
            err             <= err_n;
            rejected        <= rejected_n;
            settle_cnt      <= settle_cnt_n;
            lock_cnt        <= lock_cnt_n;
            reconfig_to_pll <= to_pll_n;
            avs_readdata    <= readdata_n;
            irq             <= irq_n;
        end
    end

    always_comb begin
        state_n      = state;
        n_cnt_n      = n_cnt;
        m_cnt_n      = m_cnt;
        c0_cnt_n     = c0_cnt;
        k_frac_n     = k_frac;
        dirty_n      = dirty;
        pend_n       = pend;
        done_n       = done;
        err_n        = err;
        rejected_n   = rejected;
        settle_cnt_n = settle_cnt;
        lock_cnt_n   = lock_cnt;
        to_pll_n     = '0;
        readdata_n   = '0;
        push_cur     = pend & (~pend + 4'd1);
        push_next    = '0;

        // Host side: shadows and START are only accepted while the sequencer is idle.
        if (avs_write) begin
            case (avs_address)
                3'd0: begin
                    if (avs_writedata[1]) done_n = 1'b0;
                    if (avs_writedata[2]) err_n = 1'b0;
                    if (avs_writedata[4]) rejected_n = 1'b0;
                end
                3'd1: begin
                    if (!idle) rejected_n = 1'b1;
                    else if (avs_writedata[0]) begin
                        done_n = 1'b0;
                        err_n  = 1'b0;
                    end
                end
                3'd2, 3'd3, 3'd4, 3'd5: begin
                    if (!idle) rejected_n = 1'b1;
                    else begin
                        case (avs_address)
                            3'd2:    n_cnt_n  = avs_writedata[15:0];
                            3'd3:    m_cnt_n  = avs_writedata[15:0];
                            3'd4:    c0_cnt_n = avs_writedata[17:0];
                            default: k_frac_n = avs_writedata;
                        endcase
                        dirty_n[avs_address - 3'd2] = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Sequencer; its status updates come last so a same-cycle host clear loses.
        case (state)
            IDLE: begin
                if (avs_write && avs_address == 3'd1 && avs_writedata[0]) begin
                    pend_n  = dirty;
                    state_n = (dirty != 4'd0) ? PUSH : START;
                end
            end
            PUSH: begin
                pend_n  = pend & ~push_cur;
                dirty_n = dirty_n & ~push_cur;
                if ((pend & ~push_cur) == 4'd0) state_n = START;
            end
            START: begin
                settle_cnt_n = 1'b0;
                state_n      = SETTLE;
            end
            SETTLE: begin
                settle_cnt_n = 1'b1;
                if (settle_cnt) state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                lock_cnt_n = '0;
                if (!pll_busy) state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (pll_locked) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (lock_cnt == LOCK_LIMIT) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (lock_cnt != 16'hFFFF) begin
                    lock_cnt_n = lock_cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // The bus word is registered, so it is built for the state being entered.
        push_next = pend_n & (~pend_n + 4'd1);
        if (state_n == PUSH) begin
            case (push_next)
                4'b0001: to_pll_n = {24'h0, 16'h0, n_cnt, ADDR_N, 2'b01};
                4'b0010: to_pll_n = {24'h0, 16'h0, m_cnt, ADDR_M, 2'b01};
                4'b0100: to_pll_n = {24'h0, 14'h0, c0_cnt, ADDR_C0, 2'b01};
                4'b1000: to_pll_n = {24'h0, k_frac, ADDR_K, 2'b01};
                default: to_pll_n = '0;
            endcase
        end else if (state_n == START) begin
            to_pll_n = 64'h2;
        end

        irq_n = done_n | err_n;

        if (avs_read) begin
            case (avs_address)
                3'd0:    readdata_n = {20'h0, dirty, 3'b000, rejected, pll_locked, err, done, !idle};
                3'd2:    readdata_n = {16'h0, n_cnt};
                3'd3:    readdata_n = {16'h0, m_cnt};
                3'd4:    readdata_n = {14'h0, c0_cnt};
                3'd5:    readdata_n = k_frac;
                default: readdata_n = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_system_pll_reconfig.sv
// Bench for soc_system_pll_reconfig: one instance against a busy/lock PLL model and a
// second with LOCK_TIMEOUT=50 whose PLL never locks; bus words and reads go through queues.
module tb_soc_system_pll_reconfig;
    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] rdata, rdata_to;
    logic [63:0] to_pll, to_pll_to, from_pll, from_pll_to;
    logic        irq, irq_to;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_at = -10;
    bit rd_d = 1'b0;

    typedef struct { logic [63:0] word; int at; } pll_ev_t;
    typedef struct { logic [31:0] exp; logic [31:0] exp_to; } rd_ev_t;
    pll_ev_t pll_q[$];
    rd_ev_t  rd_q[$];

    logic busy_m, locked_m;
    int   mcnt;

    soc_system_pll_reconfig dut (
        .refclk(refclk), .rst(rst), .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(rdata),
        .reconfig_to_pll(to_pll), .reconfig_from_pll(from_pll), .irq(irq)
    );

    soc_system_pll_reconfig #(.LOCK_TIMEOUT(50)) dut_to (
        .refclk(refclk), .rst(rst), .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(rdata_to),
        .reconfig_to_pll(to_pll_to), .reconfig_from_pll(from_pll_to), .irq(irq_to)
    );

    always #10 refclk = ~refclk;

    // PLL model: busy for 10 cycles and lock 100 cycles after a start pulse.
    always @(posedge refclk) begin
        cyc  <= cyc + 1;
        rd_d <= avs_read;
        if (rst) begin
            busy_m <= 1'b0; locked_m <= 1'b1; mcnt <= 0;
        end else if (to_pll[1]) begin
            busy_m <= 1'b1; locked_m <= 1'b0; mcnt <= 1;
        end else if (mcnt != 0) begin
            mcnt <= mcnt + 1;
            if (mcnt == 10) busy_m <= 1'b0;
            if (mcnt == 100) begin locked_m <= 1'b1; mcnt <= 0; end
        end
    end
    assign from_pll    = {62'h0, locked_m, busy_m};
    assign from_pll_to = 64'h0;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] pllWord(input logic [5:0] addr, input logic [31:0] data);
        return (64'(data) << 8) | (64'(addr) << 2) | 64'h1;
    endfunction

    // Bus monitor: every non-zero word must be the next expected one, in its cycle.
    always @(negedge refclk) begin
        pll_ev_t ev;
        if (to_pll != 64'h0) begin
            checkOutput("pll_pending", 64'(pll_q.size() != 0), 64'd1);
            if (pll_q.size() != 0) begin
                ev = pll_q.pop_front();
                checkOutput("pll_word", to_pll, ev.word);
                checkOutput("pll_cycle", 64'(cyc), 64'(ev.at));
            end
        end
    end

    always @(negedge refclk) begin
        rd_ev_t ev;
        if (rd_d) begin
            checkOutput("rd_pending", 64'(rd_q.size()), 64'd1);
            if (rd_q.size() != 0) begin
                ev = rd_q.pop_front();
                checkOutput("rd_data", 64'(rdata), 64'(ev.exp));
                checkOutput("rd_data_to", 64'(rdata_to), 64'(ev.exp_to));
            end
        end
    end

    always @(negedge refclk) begin
        if (cyc == err_at - 1) checkOutput("err_early", 64'(irq_to), 64'd0);
        if (cyc == err_at)     checkOutput("err_rise", 64'(irq_to), 64'd1);
    end

    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data, output int t);
        @(posedge refclk); #1;
        t = cyc;
        avs_address = addr; avs_writedata = data; avs_write = 1'b1;
        @(posedge refclk); #1;
        avs_write = 1'b0;
    endtask

    task automatic readReg(input logic [2:0] addr, input logic [31:0] exp, input logic [31:0] exp_to);
        rd_ev_t ev;
        @(posedge refclk); #1;
        ev.exp = exp; ev.exp_to = exp_to;
        rd_q.push_back(ev);
        avs_address = addr; avs_read = 1'b1;
        @(posedge refclk); #1;
        avs_read = 1'b0;
    endtask

    task automatic pushEv(input logic [63:0] word, input int at);
        pll_ev_t ev;
        ev.word = word; ev.at = at;
        pll_q.push_back(ev);
    endtask

    task automatic waitIrq(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge refclk);
            if (irq) break;
        end
        checkOutput("irq_wait", 64'(irq), 64'd1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, tt;
        @(posedge refclk);
        @(negedge refclk);
        checkOutput("rst_pll", to_pll, 64'h0);
        checkOutput("rst_rd", 64'(rdata), 64'h0);
        checkOutput("rst_irq", 64'(irq), 64'h0);
        @(posedge refclk); #1;
        rst = 1'b0;

        readReg(3'd2, 32'h0202, 32'h0202);
        readReg(3'd3, 32'h3737, 32'h3737);
        readReg(3'd4, 32'h20302, 32'h20302);
        readReg(3'd5, 32'h0CCCCCCD, 32'h0CCCCCCD);
        readReg(3'd0, 32'h8, 32'h0);

        $display("[TB] two dirty registers, lock after 100 cycles / timeout");
        applyStimulus(3'd3, 32'h3838, tt);
        applyStimulus(3'd5, 32'h19999999, tt);
        readReg(3'd3, 32'h3838, 32'h3838);
        readReg(3'd0, 32'hA08, 32'hA00);
        applyStimulus(3'd1, 32'h1, t);
        pushEv(pllWord(6'h04, 32'h3838), t + 1);
        pushEv(pllWord(6'h07, 32'h19999999), t + 2);
        pushEv(64'h2, t + 3);
        err_at = t + 58;
        repeat (5) @(posedge refclk);
        applyStimulus(3'd1, 32'h1, tt);
        repeat (20) @(posedge refclk);
        applyStimulus(3'd2, 32'h1111, tt);
        readReg(3'd2, 32'h0202, 32'h0202);
        readReg(3'd0, 32'h11, 32'h11);
        while (cyc < t + 70) @(posedge refclk);
        readReg(3'd0, 32'h11, 32'h14);
        waitIrq(200);
        readReg(3'd0, 32'h1A, 32'h14);
        applyStimulus(3'd0, 32'h2, tt);
        @(negedge refclk);
        checkOutput("irq_clr", 64'(irq), 64'd0);
        checkOutput("irq_err_held", 64'(irq_to), 64'd1);
        applyStimulus(3'd0, 32'h14, tt);
        readReg(3'd0, 32'h8, 32'h0);

        $display("[TB] start with nothing dirty");
        applyStimulus(3'd1, 32'h1, t);
        pushEv(64'h2, t + 1);
        err_at = t + 56;
        waitIrq(200);
        while (cyc < t + 60) @(posedge refclk);
        applyStimulus(3'd0, 32'h16, tt);
        readReg(3'd0, 32'h8, 32'h0);

        $display("[TB] reset in the middle of a push");
        applyStimulus(3'd2, 32'h1234, tt);
        applyStimulus(3'd4, 32'hFFFFFFFF, tt);
        readReg(3'd4, 32'h3FFFF, 32'h3FFFF);
        readReg(3'd0, 32'h508, 32'h500);
        applyStimulus(3'd1, 32'h1, t);
        pushEv(pllWord(6'h03, 32'h1234), t + 1);
        rst = 1'b1;
        @(posedge refclk); #1;
        rst = 1'b0;
        @(negedge refclk);
        checkOutput("rst_mid_pll", to_pll, 64'h0);
        checkOutput("rst_mid_pll_to", to_pll_to, 64'h0);
        readReg(3'd2, 32'h0202, 32'h0202);
        readReg(3'd4, 32'h20302, 32'h20302);
        readReg(3'd0, 32'h8, 32'h0);

        repeat (3) @(posedge refclk);
        checkOutput("pll_left", 64'(pll_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/soc_system_pll_reconfig.md
# soc_system_pll_reconfig

Reconfiguration controller driving the 64-bit `reconfig_to_pll` bus and monitoring the `reconfig_from_pll` bus of the `soc_system_pll_0` fractional PLL, which runs from the 50 MHz reference. The HPS programs shadow counter registers over an Avalon-MM slave. Writing the START register commits every modified shadow to the PLL, pulses reconfig start, and then waits for the PLL to go idle and re-lock, with a timeout. This lets the adder test sweep `outclk_0` frequency without a new bitstream.

## Interface
- `LOCK_TIMEOUT`, default 65535: number of `refclk` cycles in WAIT_LOCK before a timeout error is flagged.
- `refclk`  in  1  Controller clock; the same 50 MHz reference that feeds the PLL.
- `rst`  in  1  Synchronous, active-high reset.
- `avs_address`  in  3  Register select: 0 STATUS, 1 START, 2 N_CNT, 3 M_CNT, 4 C0_CNT, 5 K_FRAC.
- `avs_write` / `avs_writedata`  in  1 / 32  Register write.
- `avs_read`  in  1  Register read.
- `avs_readdata`  out  32  Read data, valid the cycle after `avs_read`.
- `reconfig_to_pll`  out  64  Bus encoding:
  - [0] write strobe
  - [1] start pulse
  - [7:2] PLL register address
  - [39:8] write data
  - [63:40] tied to 0
- `reconfig_from_pll`  in  64  Bus encoding:
  - [0] busy
  - [1] locked
  - [63:2] ignored
- `irq`  out  1  Level interrupt: high while STATUS.done or STATUS.err is set.

## Operation
- Shadow register fields and reset values (reset values equal the power-up PLL configuration):
  - N_CNT [15:0] = {hi,lo}, reset 0x0202.
  - M_CNT [15:0], reset 0x3737.
  - C0_CNT [17:0] = {odd_en, bypass, hi[7:0], lo[7:0]}, reset 0x20302.
  - K_FRAC [31:0], reset 0x0CCCCCCD.
  - Upper unused bits read as 0.
- Dirty bits:
  - Each shadow has one dirty bit; it is set by a host write and cleared when that register is pushed to the PLL.
  - All dirty bits are 0 after reset.
- PLL addresses: N 0x03, M 0x04, C0 0x05, K 0x07.
- STATUS register (read):
  - [0] busy: FSM not in IDLE.
  - [1] done.
  - [2] err.
  - [3] live locked.
  - [4] rejected.
  - [11:8] dirty bits, ordered {K, C0, M, N}.
  - Writing 1 to bit 1, 2 or 4 clears that bit. Writing STATUS never touches the FSM.
- START write:
  - With `avs_writedata[0]`=1 while IDLE, enters PUSH, clears done and err, and latches a snapshot of the dirty bits.
  - While not IDLE, START and shadow writes are dropped and rejected is set.
- FSM states:
  - IDLE.
  - PUSH: one cycle per dirty register, in order N, M, C0, K. Drives the write strobe, address and data for exactly 1 cycle each and clears that register's dirty bit. With no dirty registers, goes straight to START.
  - START: start pulse for 1 cycle.
  - SETTLE: waits 2 cycles, ignoring busy.
  - WAIT_BUSY: holds until busy=0.
  - WAIT_LOCK: a counter starts at 0.
    - If locked=1, go to IDLE and set done.
    - If the counter reaches LOCK_TIMEOUT, go to IDLE and set err, leaving done=0.
- Outputs outside PUSH/START: strobe, start, address and data fields are all 0.
- Reset mid-sequence:
  - FSM returns to IDLE; `reconfig_to_pll` goes to 0 next cycle.
  - Shadows return to their reset values; dirty, done, err and rejected clear.
  - No partial write completes.

## Timing
- All outputs are registered; every output is 0 in the cycle after `rst`.
- `avs_readdata` latency is 1 cycle; reading the shadow registers has no side effects.
- A host write to a shadow register is visible on readback the next cycle.
- Write that starts the sequence (cycle t):
  - IDLE→PUSH at the t+1 edge; first strobe visible in cycle t+1.
  - With n dirty registers, the start pulse is in cycle t+1+n.
  - SETTLE occupies cycles t+2+n and t+3+n.
- Done timing: done rises 1 cycle after locked is sampled high in WAIT_LOCK.
- Lock-timeout limit: the timeout counter is 16 bits wide and does not wrap.
- Simultaneous events:
  - A host write to STATUS done-clear in the same cycle as the FSM setting done: set wins.
  - A shadow write during the PUSH cycle of the same register: the write is rejected; the old value is pushed.

## Test plan
- Reset, then read addresses 2–5 → 0x0202, 0x3737, 0x20302, 0x0CCCCCCD. STATUS = 0x8 once the PLL model asserts locked; `reconfig_to_pll` = 0.
- Write M=0x3838 and K=0x19999999, then START → exactly two strobes in back-to-back cycles:
  - addr 0x04 with data 0x3838;
  - addr 0x07 with data 0x19999999;
  - then one start pulse, with STATUS[11:8]=0 afterward.
- Model with busy high for 10 cycles and lock after 100 cycles → done=1, irq=1, err=0. Write 0x2 to STATUS → irq=0.
- LOCK_TIMEOUT=50 with locked held low → err=1 in the cycle after counter=50, done=0, FSM in IDLE.
- START while busy, plus an N write during WAIT_LOCK → rejected=1, N readback unchanged, no extra strobe.
- Assert `rst` during PUSH after the first strobe → all-zero `reconfig_to_pll` next cycle, shadows at reset values, STATUS busy=0.
